axi_stream_master: RTL and testbench

Transmit end of the team's byte-serial AXI-Stream link. Accepts one PCK_SIZE-byte word from local logic on a start pulse, then sends it as PCK_SIZE beats on an axi_if master port. Each beat is tagged with the component ID, and tlast marks the final beat. It is the source for axi_stream_slave instances such as the seven-segment display controller, for example frequency-meter core to display.

---
 rtl/axi_stream_pkg.sv | 22 ++
 rtl/axi_if.sv | 34 +++
 rtl/axi_stream_master.sv | 90 +++++++++
 tb/tb_axi_stream_master.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_pkg.sv
// ============================================================================
// axi_stream_pkg : constants and types shared by both ends of the byte link
// Rev 1.0
// ============================================================================
`default_nettype none

package axi_stream_pkg;

   localparam int BYTE_W           = 8;
   localparam int ID_W             = 8;
   // Master and slave default to the same packet size so both ends agree.
   localparam int PCK_SIZE_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } axis_tx_state_e;

endpackage

`default_nettype wire

// File: rtl/axi_if.sv
// ============================================================================
// axi_if : byte-wide AXI-Stream bundle with component ID and packet end mark
// Rev 1.0
// ============================================================================
`default_nettype none

interface axi_if;
   import axi_stream_pkg::*;

   logic [BYTE_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;
   logic [ID_W-1:0]   tid;

   modport master (
      output tdata,
      output tvalid,
      output tlast,
      output tid,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      input  tlast,
      input  tid,
      output tready
   );

endinterface

`default_nettype wire

// File: rtl/axi_stream_master.sv
// ============================================================================
// axi_stream_master : sends one PCK_SIZE-byte word as LSB-first byte beats
// Rev 1.0
// ============================================================================
`default_nettype none

module axi_stream_master
   import axi_stream_pkg::*;
#(
   parameter int              PCK_SIZE = PCK_SIZE_DEFAULT,
   parameter logic [ID_W-1:0] DEST_ID  = 8'hFF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [PCK_SIZE*8-1:0]    tx_data,
   input  logic                     tx_start,
   output logic                     busy,
   output logic                     done,
   axi_if.master                    axi
);

   localparam int              CNT_W   = (PCK_SIZE > 1) ? $clog2(PCK_SIZE) : 1;
   localparam logic [CNT_W-1:0] c_last = CNT_W'(PCK_SIZE - 1);
   // Index of the beat before the last one; only consulted when PCK_SIZE > 1.
   localparam logic [CNT_W-1:0] c_pen  = CNT_W'((PCK_SIZE > 1) ? (PCK_SIZE - 2) : 0);

   axis_tx_state_e          r_state;
   logic [PCK_SIZE*8-1:0]   r_shreg;
   logic [CNT_W-1:0]        r_cnt;
   logic [PCK_SIZE*8-1:0]   w_shifted;

   assign w_shifted = r_shreg >> BYTE_W;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_shreg    <= '0;
         r_cnt      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         axi.tvalid <= 1'b0;
         axi.tdata  <= '0;
         axi.tlast  <= 1'b0;
         axi.tid    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               done <= 1'b0;
               if (tx_start) begin
                  r_shreg    <= tx_data;
                  r_cnt      <= '0;
                  axi.tdata  <= tx_data[BYTE_W-1:0];
                  axi.tid    <= DEST_ID;
                  axi.tlast  <= (PCK_SIZE == 1);
                  axi.tvalid <= 1'b1;
                  busy       <= 1'b1;
                  r_state    <= SEND;
               end
            end
            SEND: begin
               // Outputs are preloaded with the next beat so the bus stays registered.
               if (axi.tready) begin
                  if (r_cnt == c_last) begin
                     axi.tvalid <= 1'b0;
                     axi.tlast  <= 1'b0;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     r_state    <= DONE;
                  end else begin
                     r_shreg    <= w_shifted;
                     r_cnt      <= r_cnt + CNT_W'(1);
                     axi.tdata  <= w_shifted[BYTE_W-1:0];
                     axi.tlast  <= (r_cnt == c_pen);
                  end
               end
            end
            DONE: begin
               done    <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_axi_stream_master.sv
// ============================================================================
// tb_axi_stream_master : directed vector table plus random-backpressure packets
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_axi_stream_master;

   logic        clk = 1'b0;
   logic        rst4, start4;
   logic [31:0] data4;
   logic        busy4, done4;
   logic        rst1, start1;
   logic [7:0]  data1;
   logic        busy1, done1;

   int checks = 0;
   int errors = 0;

   axi_if bus4 ();
   axi_if bus1 ();

   axi_stream_master #(.PCK_SIZE(4), .DEST_ID(8'hFF)) dut4 (
      .clk(clk), .rst(rst4), .tx_data(data4), .tx_start(start4),
      .busy(busy4), .done(done4), .axi(bus4)
   );

   axi_stream_master #(.PCK_SIZE(1), .DEST_ID(8'h01)) dut1 (
      .clk(clk), .rst(rst1), .tx_data(data1), .tx_start(start1),
      .busy(busy1), .done(done1), .axi(bus1)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        start;
      logic [31:0] data;
      logic        ready;
      logic [19:0] exp;
   } vec_t;

   vec_t vecs[$];

   // {tvalid, tlast, tid, tdata, busy, done}
   function automatic logic [19:0] pack(input logic tv, input logic tl, input logic [7:0] id,
                                        input logic [7:0] d, input logic b, input logic dn);
      return {tv, tl, id, d, b, dn};
   endfunction

   function automatic logic [19:0] obs4();
      return {bus4.tvalid, bus4.tlast, bus4.tid, bus4.tdata, busy4, done4};
   endfunction

   function automatic logic [19:0] obs1();
      return {bus1.tvalid, bus1.tlast, bus1.tid, bus1.tdata, busy1, done1};
   endfunction

   task automatic add(input logic r, input logic s, input logic [31:0] d, input logic rdy,
                      input logic tv, input logic tl, input logic [7:0] id, input logic [7:0] td,
                      input logic b, input logic dn);
      vec_t v;
      v.rst = r; v.start = s; v.data = d; v.ready = rdy;
      v.exp = pack(tv, tl, id, td, b, dn);
      vecs.push_back(v);
   endtask

   task automatic check(input string nm, input logic [19:0] act, input logic [19:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got {tv,tl,tid,tdata,busy,done}=%h required %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_random(input int idx, input logic [31:0] w);
      int  k;
      bit  fin;
      logic hs;
      start4 = 1'b1; data4 = w; bus4.tready = 1'(($urandom_range(0, 1)));
      tick();
      check($sformatf("rnd%0d_first", idx), obs4(), pack(1'b1, 1'b0, 8'hFF, w[7:0], 1'b1, 1'b0));
      k   = 0;
      fin = 1'b0;
      for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
         hs          = 1'($urandom_range(0, 1));
         bus4.tready = hs;
         start4      = 1'($urandom_range(0, 1));
         data4       = $urandom;
         tick();
         if (hs) k++;
         if (k == 4) begin
            check($sformatf("rnd%0d_done", idx), obs4(), pack(1'b0, 1'b0, 8'hFF, w[31:24], 1'b0, 1'b1));
            fin = 1'b1;
         end else begin
            check($sformatf("rnd%0d_beat%0d", idx, k), obs4(),
                  pack(1'b1, (k == 3), 8'hFF, w[8*k +: 8], 1'b1, 1'b0));
         end
      end
      if (!fin) begin
         errors++;
         $display("FAIL rnd%0d_timeout: got %0d beats required 4", idx, k);
      end
      start4 = 1'b1;
      tick();
      check($sformatf("rnd%0d_idle", idx), obs4(), pack(1'b0, 1'b0, 8'hFF, w[31:24], 1'b0, 1'b0));
      start4 = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst4 = 1'b1; start4 = 1'b0; data4 = '0; bus4.tready = 1'b0;
      rst1 = 1'b1; start1 = 1'b0; data1 = '0; bus1.tready = 1'b0;

      // reset, and reset dominating a start
      add(1, 0, 32'h0,         0, 0, 0, 8'h00, 8'h00, 0, 0);
      add(1, 1, 32'h12345678,  1, 0, 0, 8'h00, 8'h00, 0, 0);
      // basic send, tready held high; starts during last beat and DONE ignored
      add(0, 1, 32'h12345678,  1, 1, 0, 8'hFF, 8'h78, 1, 0);
      add(0, 0, 32'h0,         1, 1, 0, 8'hFF, 8'h56, 1, 0);
      add(0, 0, 32'h0,         1, 1, 0, 8'hFF, 8'h34, 1, 0);
      add(0, 0, 32'h0,         1, 1, 1, 8'hFF, 8'h12, 1, 0);
      add(0, 1, 32'hDEADBEEF,  1, 0, 0, 8'hFF, 8'h12, 0, 1);
      add(0, 1, 32'hDEADBEEF,  1, 0, 0, 8'hFF, 8'h12, 0, 0);
      // start accepted with tready low, then backpressure 1,0,0,1,0,1,1
      add(0, 1, 32'hDEADBEEF,  0, 1, 0, 8'hFF, 8'hEF, 1, 0);
      add(0, 1, 32'h11223344,  1, 1, 0, 8'hFF, 8'hBE, 1, 0);
      add(0, 0, 32'h0,         0, 1, 0, 8'hFF, 8'hBE, 1, 0);
      add(0, 0, 32'h0,         0, 1, 0, 8'hFF, 8'hBE, 1, 0);
      add(0, 0, 32'h0,         1, 1, 0, 8'hFF, 8'hAD, 1, 0);
      add(0, 0, 32'h0,         0, 1, 0, 8'hFF, 8'hAD, 1, 0);
      add(0, 0, 32'h0,         1, 1, 1, 8'hFF, 8'hDE, 1, 0);
      add(0, 0, 32'h0,         1, 0, 0, 8'hFF, 8'hDE, 0, 1);
      add(0, 0, 32'h0,         0, 0, 0, 8'hFF, 8'hDE, 0, 0);
      // reset at beat 2 aborts, fresh packet starts from beat 0
      add(0, 1, 32'h12345678,  1, 1, 0, 8'hFF, 8'h78, 1, 0);
      add(0, 0, 32'h0,         1, 1, 0, 8'hFF, 8'h56, 1, 0);
      add(0, 0, 32'h0,         1, 1, 0, 8'hFF, 8'h34, 1, 0);
      add(1, 0, 32'h0,         1, 0, 0, 8'h00, 8'h00, 0, 0);
      add(0, 1, 32'hCAFEF00D,  1, 1, 0, 8'hFF, 8'h0D, 1, 0);
      add(0, 0, 32'h0,         1, 1, 0, 8'hFF, 8'hF0, 1, 0);
      add(0, 0, 32'h0,         1, 1, 0, 8'hFF, 8'hFE, 1, 0);
      add(0, 0, 32'h0,         1, 1, 1, 8'hFF, 8'hCA, 1, 0);
      add(0, 0, 32'h0,         1, 0, 0, 8'hFF, 8'hCA, 0, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         rst4        = vecs[i].rst;
         start4      = vecs[i].start;
         data4       = vecs[i].data;
         bus4.tready = vecs[i].ready;
         tick();
         check($sformatf("vec%0d", i), obs4(), vecs[i].exp);
      end
      rst4 = 1'b0; start4 = 1'b0; bus4.tready = 1'b0;
      tick();

      for (int p = 0; p < 20; p++) send_random(p, $urandom);

      // single-byte packets
      check("p1_reset", obs1(), pack(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0));
      rst1 = 1'b0; start1 = 1'b1; data1 = 8'hA5; bus1.tready = 1'b1;
      tick();
      check("p1_beat", obs1(), pack(1'b1, 1'b1, 8'h01, 8'hA5, 1'b1, 1'b0));
      start1 = 1'b0;
      tick();
      check("p1_done", obs1(), pack(1'b0, 1'b0, 8'h01, 8'hA5, 1'b0, 1'b1));
      tick();
      check("p1_idle", obs1(), pack(1'b0, 1'b0, 8'h01, 8'hA5, 1'b0, 1'b0));
      start1 = 1'b1; data1 = 8'h3C; bus1.tready = 1'b0;
      tick();
      start1 = 1'b0; data1 = 8'hFF;
      tick();
      check("p1_stall", obs1(), pack(1'b1, 1'b1, 8'h01, 8'h3C, 1'b1, 1'b0));
      bus1.tready = 1'b1;
      tick();
      check("p1_stall_done", obs1(), pack(1'b0, 1'b0, 8'h01, 8'h3C, 1'b0, 1'b1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
